// File: rtl/regfile_dump_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_scheduler_pkg
//  Description : Shared constants and state encoding for the register-file
//                dump scheduler and its helper search block.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_scheduler_pkg;

    localparam int         c_NUM_REGS    = 32;
    localparam int         c_REG_AW      = 5;
    localparam logic [7:0] c_SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] c_EOF_DEFAULT = 8'h5A;

    // Every byte-sending phase has its own state so the byte mux and the
    // successor choice can both key off the state alone.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_CNT  = 3'd2,
        ST_READ = 3'd3,
        ST_CAPT = 3'd4,
        ST_ADDR = 3'd5,
        ST_DATA = 3'd6,
        ST_EOF  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_find_next.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_find_next
//  Description : Combinational lowest-set-bit search plus population count
//                over a register mask.
//  Ports       : i_vec        - mask to search
//                o_next_idx   - index of the lowest set bit (0 if none)
//                o_next_valid - at least one bit set
//                o_count      - number of set bits
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_find_next
    import regfile_dump_scheduler_pkg::*;
(
    input  logic [c_NUM_REGS-1:0] i_vec,
    output logic [c_REG_AW-1:0]   o_next_idx,
    output logic                  o_next_valid,
    output logic [7:0]            o_count
);

    // Scanning from the top down lets the last hit (the lowest index) win.
    always_comb begin
        o_next_idx   = '0;
        o_next_valid = 1'b0;
        o_count      = '0;
        for (int i = c_NUM_REGS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_next_idx   = c_REG_AW'(i);
                o_next_valid = 1'b1;
            end
            o_count = o_count + 8'(i_vec[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_scheduler
//  Description : Tracks registers written by the processor and, on request,
//                streams the dirty ones to the host as a framed UART packet:
//                SOF, N, {addr, d0..d3} per dirty register, EOF.
//  Ports       : clk12      - system clock
//                rst        - asynchronous active-high reset
//                wr_en/wr_addr - snooped processor regfile write port
//                dump_req   - 1-cycle dump request pulse
//                busy/done  - packet in progress / end-of-packet pulse
//                rf_rd_addr/rf_rd_data - regfile second read port (1-cycle)
//                tx_data/tx_start/tx_ready - uart_tx byte handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_scheduler
    import regfile_dump_scheduler_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE  = c_SOF_DEFAULT,
    parameter logic [7:0] EOF_BYTE  = c_EOF_DEFAULT,
    parameter bit         FULL_DUMP = 1'b0
) (
    input  logic                clk12,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [c_REG_AW-1:0] wr_addr,
    input  logic                dump_req,
    output logic                busy,
    output logic                done,
    output logic [c_REG_AW-1:0] rf_rd_addr,
    input  logic [31:0]         rf_rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_ready
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_NUM_REGS-1:0] r_live;
    logic [c_NUM_REGS-1:0] w_live_nxt;
    logic [c_NUM_REGS-1:0] r_snap;
    logic [c_NUM_REGS-1:0] r_sent;
    logic                  r_pending;
    logic [7:0]            r_count;
    logic [c_REG_AW-1:0]   r_idx;
    logic [c_REG_AW-1:0]   r_rd_addr;
    logic [31:0]           r_word;
    logic [1:0]            r_bsel;
    logic                  r_seen_low;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_send;
    logic                  w_byte_done;
    logic                  w_start;
    logic                  w_load_rd;
    logic                  w_capt;
    logic                  w_bsel_inc;
    logic                  w_eof_done;
    logic [c_NUM_REGS-1:0] w_start_mask;
    logic [c_NUM_REGS-1:0] w_search;
    logic [c_REG_AW-1:0]   w_next_idx;
    logic                  w_next_valid;
    logic [7:0]            w_count;

    assign w_start_mask = FULL_DUMP ? {c_NUM_REGS{1'b1}} : r_live;

    // In IDLE the search block counts the mask about to be snapped; during
    // a packet it finds the next register still to be sent.
    assign w_search = (r_state == ST_IDLE) ? w_start_mask : (r_snap & ~r_sent);

    regfile_find_next u_find_next (
        .i_vec        (w_search),
        .o_next_idx   (w_next_idx),
        .o_next_valid (w_next_valid),
        .o_count      (w_count)
    );

    assign w_in_send = (r_state == ST_SOF)  || (r_state == ST_CNT) ||
                       (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                       (r_state == ST_EOF);

    // A byte is finished once uart_tx has gone busy and come back ready.
    assign w_byte_done = w_in_send && r_seen_low && tx_ready;
    assign w_eof_done  = (r_state == ST_EOF) && w_byte_done;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load_rd   = 1'b0;
        w_capt      = 1'b0;
        w_bsel_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dump_req || r_pending) begin
                    w_state_nxt = ST_SOF;
                    w_start     = 1'b1;
                end
            end
            ST_SOF: if (w_byte_done) w_state_nxt = ST_CNT;
            ST_CNT: begin
                if (w_byte_done) begin
                    if (w_next_valid) begin
                        w_state_nxt = ST_READ;
                        w_load_rd   = 1'b1;
                    end else begin
                        w_state_nxt = ST_EOF;
                    end
                end
            end
            ST_READ: w_state_nxt = ST_CAPT;
            ST_CAPT: begin
                w_state_nxt = ST_ADDR;
                w_capt      = 1'b1;
            end
            ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_byte_done) begin
                    if (r_bsel != 2'd3) begin
                        w_bsel_inc = 1'b1;
                    end else if (w_next_valid) begin
                        w_state_nxt = ST_READ;
                        w_load_rd   = 1'b1;
                    end else begin
                        w_state_nxt = ST_EOF;
                    end
                end
            end
            ST_EOF: if (w_byte_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear is applied before set so a write landing in the capture cycle
    // keeps the register dirty for the following dump.
    always_comb begin
        w_live_nxt = r_live;
        if (w_capt) begin
            w_live_nxt[r_idx] = 1'b0;
        end
        if (wr_en && (wr_addr != '0)) begin
            w_live_nxt[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_live     <= '0;
            r_snap     <= '0;
            r_sent     <= '0;
            r_pending  <= 1'b0;
            r_count    <= '0;
            r_idx      <= '0;
            r_rd_addr  <= '0;
            r_word     <= '0;
            r_bsel     <= '0;
            r_seen_low <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= w_live_nxt;
            r_done  <= w_eof_done;

            if (w_start) begin
                r_snap    <= w_start_mask;
                r_sent    <= '0;
                r_count   <= w_count;
                r_pending <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                if (dump_req) begin
                    r_pending <= 1'b1;
                end
                if (w_eof_done) begin
                    r_busy <= 1'b0;
                end
            end

            if (w_load_rd) begin
                r_rd_addr <= w_next_idx;
                r_idx     <= w_next_idx;
            end

            if (w_capt) begin
                r_word        <= rf_rd_data;
                r_sent[r_idx] <= 1'b1;
                r_bsel        <= '0;
            end else if (w_bsel_inc) begin
                r_bsel <= r_bsel + 2'd1;
            end

            if (w_byte_done) begin
                r_seen_low <= 1'b0;
            end else if (w_in_send && !tx_ready) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            ST_SOF:  tx_data = SOF_BYTE;
            ST_CNT:  tx_data = r_count;
            ST_ADDR: tx_data = {3'b000, r_idx};
            ST_DATA: tx_data = r_word[{r_bsel, 3'b000} +: 8];
            ST_EOF:  tx_data = EOF_BYTE;
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_start   = w_in_send && !r_seen_low;
    assign busy       = r_busy;
    assign done       = r_done;
    assign rf_rd_addr = r_rd_addr;

endmodule
`default_nettype wire
